mux_sel_sequencer: RTL

- Upstream control stage for the team's tristate 2:1 multiplexer cells.
- Arbitrates two requesters for the shared mux output and drives the mux select line `sel`.
- Inserts break-before-make dead time whenever `sel` changes, so the bufif0/bufif1 pair never drives the output simultaneously during their rise/fall/turn-off delays.
- Enforces round-robin fairness with a bounded hold time.

---
 rtl/mux_sel_pkg.sv | 38 +++
 rtl/mux_dead_timer.sv | 40 ++++
 rtl/mux_sel_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared types and constants for the tristate 2:1 mux select
// controllers.
//   state_e        : controller state (IDLE / DEAD / ACTIVE)
//   SEL_IN0/IN1    : select-line encodings (0 routes in0, 1 routes in1)
//   *_MIN / *_MAX  : legal parameter ranges, checked at elaboration
//   pick_target    : arbitration helper (single requester wins, tie -> !last)
package mux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  localparam int DEAD_CYCLES_MIN = 1;
  localparam int DEAD_CYCLES_MAX = 15;
  localparam int MAX_HOLD_MIN    = 1;
  localparam int MAX_HOLD_MAX    = 255;

  // A lone requester always wins; on a tie the one that was not served
  // last gets the output, which gives round-robin fairness.
  function automatic logic pick_target(input logic req0, input logic req1,
                                       input logic last);
    logic tgt;
    if (req0 && !req1) begin
      tgt = SEL_IN0;
    end else if (req1 && !req0) begin
      tgt = SEL_IN1;
    end else begin
      tgt = ~last;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/mux_dead_timer.sv
// mux_dead_timer: loadable down-counter used to time break-before-make gaps.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (count cleared)
//   load_i     : load load_val_i (has priority over en_i)
//   load_val_i : number of cycles to time
//   en_i       : decrement enable (stops at zero, never wraps)
//   done_o     : high while count == 1, i.e. during the last timed cycle
module mux_dead_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == W'(1));

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: arbitrates two requesters for a tristate 2:1 mux and
// drives its select line with break-before-make dead time on every change.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req0/req1 : requests for in0 / in1
//   sel       : mux select (0 = in0, 1 = in1)
//   sel_valid : mux output valid, driven by exactly one source
//   gnt0/gnt1 : ownership grants
//   busy      : controller not IDLE
// All outputs are registered; they are computed from the next state so they
// change on the same edge as the state they describe.
module mux_sel_sequencer
  import mux_sel_pkg::*;
#(
  parameter int DEAD_CYCLES = 2,
  parameter int MAX_HOLD    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic sel,
  output logic sel_valid,
  output logic gnt0,
  output logic gnt1,
  output logic busy
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);

  if (DEAD_CYCLES < DEAD_CYCLES_MIN || DEAD_CYCLES > DEAD_CYCLES_MAX ||
      MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_params
    $error("mux_sel_sequencer: DEAD_CYCLES or MAX_HOLD out of range");
  end

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          target;
  logic          granted_req, other_req;
  logic          dead_load, dead_done;
  logic          sel_valid_q, busy_q;
  logic [1:0]    gnt_q;

  mux_dead_timer #(.W(DW)) u_dead_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dead_load),
    .load_val_i (DEAD_LOAD),
    .en_i       (state_q == DEAD),
    .done_o     (dead_done)
  );

  always_comb begin
    target      = pick_target(req0, req1, last_q);
    granted_req = (sel_q == SEL_IN1) ? req1 : req0;
    other_req   = (sel_q == SEL_IN1) ? req0 : req1;
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    hold_d      = hold_q;
    dead_load   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          if (target == sel_q) begin
            // Mux already points at the winner: no dead time needed.
            state_d = ACTIVE;
          end else begin
            state_d   = DEAD;
            sel_d     = target;
            dead_load = 1'b1;
          end
        end
      end
      DEAD: begin
        // Requests are ignored here; the chosen target gets the grant.
        if (dead_done) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!granted_req || (other_req && (hold_q >= HOLD_SAT))) begin
          if (other_req) begin
            // Switch straight over without an IDLE cycle.
            state_d   = DEAD;
            sel_d     = ~sel_q;
            dead_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q < HOLD_SAT) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == ACTIVE) && (state_q != ACTIVE)) begin
      last_d = sel_d;
      hold_d = HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= SEL_IN0;
      last_q      <= SEL_IN1;  // requester 0 wins the first tie
      hold_q      <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      sel_valid_q <= (state_d == ACTIVE);
      busy_q      <= (state_d != IDLE);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    localparam logic SEL_GI = (gi == 1) ? SEL_IN1 : SEL_IN0;
    always_ff @(posedge clk) begin
      if (rst) begin
        gnt_q[gi] <= 1'b0;
      end else begin
        gnt_q[gi] <= (state_d == ACTIVE) && (sel_d == SEL_GI);
      end
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign busy      = busy_q;

endmodule
